ttn_pll_lock_det: RTL

- Receive-side companion to the PLL feedback (M) counter. Consumes the divided feedback clock and the reference clock as sampled data on a fast system clock.
- Measures both periods in system-clock cycles and compares them.
- Asserts `locked` after a run of matching periods; drops it after repeated mismatches or a lost feedback edge.
- Used by the PLL model and the test harness as the lock indicator.

---
 rtl/ttn_pll_lock_det.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ttn_pll_lock_det.sv
// ttn_pll_lock_det: PLL lock detector.
// Measures ref/fb periods in clk cycles and tracks lock.
module ttn_pll_lock_det #(
    parameter int PERIOD_W   = 16,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                ref_in,
    input  logic                fb_in,
    output logic                locked,
    output logic                lock_lost,
    output logic [PERIOD_W-1:0] ref_period,
    output logic [PERIOD_W-1:0] fb_period,
    output logic                period_valid
);

    localparam logic [PERIOD_W-1:0] PMAX     = '1;
    localparam logic [PERIOD_W:0]   TOL_W    = (PERIOD_W+1)'(TOL);
    localparam logic [7:0]          LOCK_N   = 8'(LOCK_CNT);
    localparam logic [7:0]          UNLOCK_N = 8'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                clr;
    logic [2:0]          ref_sync;
    logic [2:0]          fb_sync;
    logic                ref_rise;
    logic                fb_rise;
    logic [PERIOD_W-1:0] ref_cnt;
    logic [PERIOD_W-1:0] fb_cnt;
    logic [PERIOD_W-1:0] ref_inc;
    logic [PERIOD_W-1:0] fb_inc;
    logic [PERIOD_W-1:0] fb_cur;
    logic                ref_seen;
    logic                fb_seen;
    logic                ref_got;
    logic                fb_got;
    logic                fb_new;
    logic                ref_latch;
    logic                fb_latch;
    logic                fb_avail;
    logic                fb_stall;
    logic                cmp_evt;
    logic                is_match;
    logic [PERIOD_W:0]   ref_x;
    logic [PERIOD_W:0]   fb_x;
    logic [PERIOD_W:0]   diff;
    logic [7:0]          match_cnt;
    logic [7:0]          miss_cnt;
    logic [7:0]          match_n;
    logic [7:0]          miss_n;
    logic                lost_n;

    assign clr       = reset | ~enable;
    assign ref_rise  = ref_sync[1] & ~ref_sync[2];
    assign fb_rise   = fb_sync[1] & ~fb_sync[2];
    assign ref_inc   = (ref_cnt == PMAX) ? PMAX : ref_cnt + 1'b1;
    assign fb_inc    = (fb_cnt == PMAX) ? PMAX : fb_cnt + 1'b1;
    assign ref_latch = ref_rise & ref_seen;
    assign fb_latch  = fb_rise & fb_seen;

    // A same-cycle fb latch counts as fresh and is the value compared.
    assign fb_cur    = fb_latch ? fb_inc : fb_period;
    assign fb_avail  = fb_new | fb_latch;
    assign fb_stall  = (fb_cnt == PMAX);
    assign cmp_evt   = ref_rise & period_valid;

    assign ref_x     = {1'b0, ref_inc};
    assign fb_x      = {1'b0, fb_cur};
    assign diff      = (ref_x >= fb_x) ? ref_x - fb_x : fb_x - ref_x;
    assign is_match  = fb_avail & (diff <= TOL_W) &
                       (ref_inc != PMAX) & (fb_cur != PMAX);

    // Two-flop synchronizers plus an edge-detect stage per input.
    always_ff @(posedge clk) begin
        if (clr) begin
            ref_sync <= '0;
            fb_sync  <= '0;
        end else begin
            ref_sync <= {ref_sync[1:0], ref_in};
            fb_sync  <= {fb_sync[1:0], fb_in};
        end
    end

    // Saturating period counters and latched period outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            ref_cnt      <= '0;
            fb_cnt       <= '0;
            ref_seen     <= 1'b0;
            fb_seen      <= 1'b0;
            ref_got      <= 1'b0;
            fb_got       <= 1'b0;
            ref_period   <= '0;
            fb_period    <= '0;
            period_valid <= 1'b0;
            fb_new       <= 1'b0;
        end else begin
            ref_cnt      <= ref_rise ? '0 : ref_inc;
            fb_cnt       <= fb_rise ? '0 : fb_inc;
            period_valid <= ref_got & fb_got;
            if (ref_rise) begin
                ref_seen <= 1'b1;
            end
            if (fb_rise) begin
                fb_seen <= 1'b1;
            end
            if (ref_latch) begin
                ref_period <= ref_inc;
                ref_got    <= 1'b1;
            end
            if (fb_latch) begin
                fb_period <= fb_inc;
                fb_got    <= 1'b1;
            end
            if (cmp_evt) begin
                fb_new <= 1'b0;
            end else if (fb_latch) begin
                fb_new <= 1'b1;
            end
        end
    end

    // Lock state register and registered lock outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state     <= state_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            locked    <= (state_n == LOCKED);
            lock_lost <= lost_n;
        end
    end

    // Next-state: count matches to lock, misses or fb stall to unlock.
    always_comb begin
        state_n = state;
        match_n = match_cnt;
        miss_n  = miss_cnt;
        lost_n  = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = ACQUIRE;
            end
            ACQUIRE: begin
                if (cmp_evt) begin
                    if (!is_match) begin
                        match_n = '0;
                    end else if (match_cnt + 8'd1 == LOCK_N) begin
                        state_n = LOCKED;
                        match_n = '0;
                        miss_n  = '0;
                    end else begin
                        match_n = match_cnt + 8'd1;
                    end
                end
            end
            LOCKED: begin
                if (fb_stall) begin
                    state_n = ACQUIRE;
                    lost_n  = 1'b1;
                    match_n = '0;
                    miss_n  = '0;
                end else if (cmp_evt) begin
                    if (is_match) begin
                        miss_n = '0;
                    end else if (miss_cnt + 8'd1 == UNLOCK_N) begin
                        state_n = ACQUIRE;
                        lost_n  = 1'b1;
                        match_n = '0;
                        miss_n  = '0;
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
